// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
//   Shared types and default sizing for the MIPS shared-memory-port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE / ACCESS / RESP)
//   - owner_t     : which requester owns the current access (IF / MEM)
//   - DEF_*       : default parameter values for mem_port_arbiter
package mips_mem_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_TIMEOUT_CYC  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences the single shared memory port between instruction fetch
//   (read-only) and the MEM stage (load/store). One access at a time over a
//   variable-latency req/ack SRAM handshake; read data is returned with a
//   one-cycle done pulse. MEM has priority, but a fetch that has waited
//   STARVE_LIMIT cycles wins the next arbitration. A watchdog aborts any
//   access that sees no ack within TIMEOUT_CYC cycles.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_done) and address
//   if_rdata/if_done         fetch data and one-cycle completion pulse
//   mem_rd_req/mem_wr_req    MEM-stage load/store request (held until mem_done)
//   mem_addr/mem_wdata       MEM-stage address and store data
//   mem_rdata/mem_done       load data and one-cycle completion pulse
//   stall_if/stall_mem       combinational pipeline freeze for IF / MEM
//   sram_req/sram_we         memory request and write enable
//   sram_addr/sram_wdata     memory address and write data
//   sram_rdata/sram_ack      memory read data and completion
//   timeout_err              sticky watchdog flag, cleared only by reset
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  output logic              timeout_err
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic              r_sram_req;
  logic              r_sram_we;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_done;
  logic              r_mem_done;
  logic              r_timeout_err;
  logic [WDOG_W-1:0] r_wdog;
  logic [WAIT_W-1:0] r_if_wait;

  logic w_mem_any;
  logic w_grant;
  logic w_if_wins;
  logic w_grant_if;
  logic w_if_owns;

  assign w_mem_any  = mem_rd_req | mem_wr_req;
  assign w_grant    = (r_state == IDLE) & (if_req | w_mem_any);
  // Fetch wins when MEM is quiet or when fetch has been starved long enough.
  assign w_if_wins  = if_req & (~w_mem_any | (r_if_wait >= WAIT_MAX));
  assign w_grant_if = w_grant & w_if_wins;
  assign w_if_owns  = (r_state != IDLE) & (r_owner == OWN_IF);

  // Stalls are combinational so the pipeline is released in the done cycle.
  assign stall_if  = if_req & ~r_if_done;
  assign stall_mem = w_mem_any & ~r_mem_done;

  assign sram_req    = r_sram_req;
  assign sram_we     = r_sram_we;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;
  assign if_rdata    = r_if_rdata;
  assign if_done     = r_if_done;
  assign mem_rdata   = r_mem_rdata;
  assign mem_done    = r_mem_done;
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_owner       <= OWN_IF;
      r_sram_req    <= 1'b0;
      r_sram_we     <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_wdata  <= '0;
      r_if_rdata    <= '0;
      r_mem_rdata   <= '0;
      r_if_done     <= 1'b0;
      r_mem_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wdog        <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state    <= ACCESS;
            r_sram_req <= 1'b1;
            r_wdog     <= '0;
            if (w_if_wins) begin
              r_owner      <= OWN_IF;
              r_sram_addr  <= if_addr;
              r_sram_we    <= 1'b0;
              r_sram_wdata <= '0;
            end else begin
              // Load and store asserted together is issued as a store.
              r_owner      <= OWN_MEM;
              r_sram_addr  <= mem_addr;
              r_sram_we    <= mem_wr_req;
              r_sram_wdata <= mem_wdata;
            end
          end
        end
        ACCESS: begin
          if (sram_ack) begin
            r_sram_req <= 1'b0;
            r_state    <= RESP;
            if (r_owner == OWN_IF) begin
              r_if_rdata <= sram_rdata;
              r_if_done  <= 1'b1;
            end else begin
              r_mem_rdata <= sram_rdata;
              r_mem_done  <= 1'b1;
            end
          end else if (r_wdog == WDOG_LAST) begin
            // Hung access: give up, return zero data and flag it permanently.
            r_sram_req    <= 1'b0;
            r_state       <= RESP;
            r_timeout_err <= 1'b1;
            if (r_owner == OWN_IF) begin
              r_if_rdata <= '0;
              r_if_done  <= 1'b1;
            end else begin
              r_mem_rdata <= '0;
              r_mem_done  <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Fetch age: counts cycles a fetch waits while someone else holds the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_wait <= '0;
    end else if (!if_req || w_grant_if) begin
      r_if_wait <= '0;
    end else if (!w_if_owns && (r_if_wait != WAIT_MAX)) begin
      r_if_wait <= r_if_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized and directed stimulus for mem_port_arbiter. A requester
//   process drives IF/MEM requests, an SRAM model answers with programmable
//   latency, and a negedge monitor compares every DUT output against a
//   transaction-level model held in queues.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_rd_req, mem_wr_req;
  logic [AW-1:0] if_addr, mem_addr, sram_addr;
  logic [DW-1:0] mem_wdata, if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic          if_done, mem_done, stall_if, stall_mem;
  logic          sram_req, sram_we, sram_ack, timeout_err;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model ----------------
  int          lat_mode = -1;   // <0 random 0..4, otherwise fixed wait cycles
  bit          use_fix  = 0;
  logic [31:0] fix_data = '0;
  bit          spur_en  = 0;    // random acks while no request is outstanding
  int          sr_left  = 0;
  bit          sr_done  = 0;
  bit          sr_prev  = 0;

  initial begin
    sram_ack   = 1'b0;
    sram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      sram_ack = 1'b0;
      if (sram_req) begin
        if (!sr_prev) sr_left = (lat_mode < 0) ? int'($urandom_range(0, 4)) : lat_mode;
        if (!sr_done) begin
          if (sr_left == 0) begin
            sram_ack   = 1'b1;
            sram_rdata = use_fix ? fix_data : $urandom;
            sr_done    = 1;
          end else begin
            sr_left--;
          end
        end
      end else begin
        sr_done = 0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          sram_ack   = 1'b1;
          sram_rdata = $urandom;
        end
      end
      sr_prev = sram_req;
    end
  end

  // ---------------- reference model + monitor ----------------
  int          cyc = 0;
  bit          free = 1;        // arbiter able to grant in this cycle
  bit          gpend = 0;       // grant decided last cycle, access starts now
  int          g_own;           // 0 = IF, 1 = MEM
  logic [31:0] g_addr, g_wdata;
  bit          g_we;
  bit          in_acc = 0;
  int          acc_k, acc_own;
  logic [31:0] acc_addr, acc_wdata;
  bit          acc_we;
  int          done_cyc = -10;
  int          done_own;
  bit          done_we;
  bit          exp_to = 0;
  int          since = -1;      // cycle at which the current fetch wait began
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  int          gl_own[$];
  bit          gl_we[$];
  bit          exp_ifd, exp_memd, mem_any;
  bit          s_if_done = 0, s_mem_done = 0, s_sram_req = 0, s_timeout_err = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      free = 1; gpend = 0; in_acc = 0; done_cyc = -10; exp_to = 0; since = -1;
      if_q.delete(); mem_q.delete();
    end else begin
      chk("timeout_err", timeout_err, exp_to);
      if (gpend) begin
        chk("grant_req", sram_req, 1);
        chk("grant_addr", sram_addr, g_addr);
        chk("grant_we", sram_we, g_we);
        if (g_we) chk("grant_wdata", sram_wdata, g_wdata);
        gl_own.push_back(g_own);
        gl_we.push_back(g_we);
        gpend = 0; in_acc = 1; acc_k = 0; acc_own = g_own;
        acc_addr = g_addr; acc_we = g_we; acc_wdata = g_wdata;
      end else if (in_acc) begin
        chk("hold_req", sram_req, 1);
        chk("hold_addr", sram_addr, acc_addr);
        chk("hold_we", sram_we, acc_we);
        if (acc_we) chk("hold_wdata", sram_wdata, acc_wdata);
      end else begin
        chk("idle_req", sram_req, 0);
      end

      exp_ifd  = (cyc == done_cyc) && (done_own == 0);
      exp_memd = (cyc == done_cyc) && (done_own == 1);
      chk("if_done", if_done, exp_ifd);
      chk("mem_done", mem_done, exp_memd);
      if (exp_ifd && if_q.size() > 0) chk("if_rdata", if_rdata, if_q.pop_front());
      if (exp_memd && !done_we && mem_q.size() > 0) chk("mem_rdata", mem_rdata, mem_q.pop_front());
      chk("stall_if", stall_if, if_req & ~exp_ifd);
      chk("stall_mem", stall_mem, (mem_rd_req | mem_wr_req) & ~exp_memd);

      if (in_acc) begin
        acc_k++;
        if (sram_ack || acc_k == TO) begin
          if (!acc_we) begin
            if (acc_own == 0) if_q.push_back(sram_ack ? sram_rdata : 32'h0);
            else              mem_q.push_back(sram_ack ? sram_rdata : 32'h0);
          end
          if (!sram_ack) exp_to = 1;
          done_cyc = cyc + 1; done_own = acc_own; done_we = acc_we; in_acc = 0;
        end
      end

      mem_any = mem_rd_req | mem_wr_req;
      if (!if_req) since = -1;
      else if (since < 0) since = cyc;
      if (free && (if_req || mem_any)) begin
        if (if_req && (!mem_any || (cyc - since) >= SL)) begin
          g_own = 0; g_addr = if_addr; g_we = 0; g_wdata = '0;
        end else begin
          g_own = 1; g_addr = mem_addr; g_we = mem_wr_req; g_wdata = mem_wdata;
        end
        gpend = 1; free = 0;
      end
      if (cyc == done_cyc) begin
        free = 1;
        if (done_own == 0) since = cyc + 1;
      end
    end
    s_if_done     = if_done;
    s_mem_done    = mem_done;
    s_sram_req    = sram_req;
    s_timeout_err = timeout_err;
  end

  // ---------------- requesters ----------------
  bit auto_mode = 0;
  bit if_keep = 0;
  bit mem_keep = 0;
  int n_ifd = 0;
  int n_memd = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pick_mem_kind();
    int k;
    k = $urandom_range(0, 2);
    mem_rd_req = (k != 1);
    mem_wr_req = (k != 0);
    mem_addr   = $urandom;
    mem_wdata  = $urandom;
  endtask

  task automatic tick();
    step();
    if (if_req && s_if_done) begin
      n_ifd++;
      if (if_keep || (auto_mode && $urandom_range(0, 1) == 1)) if_addr = $urandom;
      else if_req = 1'b0;
    end else if (!if_req && auto_mode && $urandom_range(0, 2) == 0) begin
      if_req  = 1'b1;
      if_addr = $urandom;
    end
    if ((mem_rd_req || mem_wr_req) && s_mem_done) begin
      n_memd++;
      if (auto_mode && $urandom_range(0, 1) == 1) begin
        pick_mem_kind();
      end else if (mem_keep) begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end else begin
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
      end
    end else if (!(mem_rd_req || mem_wr_req) && auto_mode && $urandom_range(0, 2) == 0) begin
      pick_mem_kind();
    end
  endtask

  task automatic run_until_dones(input int nif, input int nmem, input int max);
    int n = 0;
    while ((n_ifd < nif || n_memd < nmem) && n < max) begin
      tick();
      n++;
    end
    chk("dones_seen", {n_ifd >= nif, n_memd >= nmem}, 2'b11);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sram_req"}, sram_req, 0);
    chk({tag, "_sram_we"}, sram_we, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_sram_wdata"}, sram_wdata, 0);
    chk({tag, "_if_done"}, if_done, 0);
    chk({tag, "_mem_done"}, mem_done, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_stall_if"}, stall_if, 0);
    chk({tag, "_stall_mem"}, stall_mem, 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    if_req = 0; mem_rd_req = 0; mem_wr_req = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst = 1'b1;

    // IF read, two wait cycles, fixed data
    lat_mode = 2; use_fix = 1; fix_data = 32'hDEADBEEF;
    step();
    if_req = 1; if_addr = 32'h0000_0040;
    n_ifd = 0; n_memd = 0;
    run_until_dones(1, 0, 20);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    use_fix = 0;

    // MEM store
    lat_mode = -1; gl_own.delete(); gl_we.delete();
    mem_wr_req = 1; mem_addr = 32'h100; mem_wdata = 32'h12345678;
    n_ifd = 0; n_memd = 0;
    run_until_dones(0, 1, 20);
    chk("t2_grants", gl_we.size(), 1);
    if (gl_we.size() >= 1) chk("t2_we", gl_we[0], 1);

    // Simultaneous IF + MEM load, zero-wait memory: MEM first, then IF
    lat_mode = 0; gl_own.delete();
    step();
    if_req = 1; if_addr = 32'h200; mem_rd_req = 1; mem_addr = 32'h300;
    n_ifd = 0; n_memd = 0;
    run_until_dones(1, 1, 30);
    chk("t3_grants", gl_own.size(), 2);
    if (gl_own.size() >= 2) begin
      chk("t3_first_mem", gl_own[0], 1);
      chk("t3_then_if", gl_own[1], 0);
    end

    // Continuous MEM loads: IF wins once its wait reaches the limit
    gl_own.delete(); mem_keep = 1;
    step();
    if_req = 1; if_addr = 32'h400; mem_rd_req = 1; mem_addr = 32'h500;
    n_ifd = 0; n_memd = 0;
    run_until_dones(1, 0, 60);
    mem_keep = 0;
    cnt = 0;
    while ((mem_rd_req || mem_wr_req) && cnt < 40) begin tick(); cnt++; end
    chk("t4_grants_ge3", gl_own.size() >= 3, 1);
    if (gl_own.size() >= 3) begin
      chk("t4_g0_mem", gl_own[0], 1);
      chk("t4_g1_mem", gl_own[1], 1);
      chk("t4_g2_if", gl_own[2], 0);
    end

    // Watchdog: memory never acks
    lat_mode = 1000;
    step();
    if_req = 1; if_addr = 32'h600;
    n_ifd = 0; n_memd = 0; cnt = 0;
    for (int i = 0; i < 100 && n_ifd < 1; i++) begin
      tick();
      if (s_sram_req) cnt++;
    end
    chk("t5_done", n_ifd, 1);
    chk("t5_req_cycles", cnt, TO);
    chk("t5_timeout_err", s_timeout_err, 1);
    chk("t5_if_rdata", if_rdata, 0);

    // Sticky flag survives a later good access
    lat_mode = 1;
    step();
    if_req = 1; if_addr = 32'h700;
    n_ifd = 0; n_memd = 0;
    run_until_dones(1, 0, 20);
    chk("t5_sticky", s_timeout_err, 1);

    // Load and store together issue a write
    lat_mode = -1; gl_we.delete();
    step();
    mem_rd_req = 1; mem_wr_req = 1; mem_addr = 32'h800; mem_wdata = 32'hCAFEF00D;
    n_ifd = 0; n_memd = 0;
    run_until_dones(0, 1, 20);
    chk("t6_grants", gl_we.size(), 1);
    if (gl_we.size() >= 1) chk("t6_we", gl_we[0], 1);

    // Asynchronous reset in the middle of an access
    lat_mode = 1000;
    step();
    mem_rd_req = 1; mem_addr = 32'h900;
    cnt = 0;
    while (!s_sram_req && cnt < 10) begin tick(); cnt++; end
    chk("rst_setup_req", s_sram_req, 1);
    repeat (3) step();
    @(posedge clk); #3;
    rst = 1'b0;
    if_req = 0; mem_rd_req = 0; mem_wr_req = 0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    lat_mode = -1;

    // Random traffic with spurious acks between accesses
    auto_mode = 1; spur_en = 1;
    repeat (3000) tick();
    auto_mode = 0;
    cnt = 0;
    while ((if_req || mem_rd_req || mem_wr_req) && cnt < 200) begin tick(); cnt++; end
    chk("drain_idle", {if_req, mem_rd_req, mem_wr_req}, 3'b000);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared memory port of the MIPS pipeline between instruction fetch (read-only) and the MEM stage (read/write). Grants one access at a time over a variable-latency req/ack SRAM handshake, returns read data with a one-cycle done pulse, and drives stall signals that freeze the IF and MEM pipeline registers while an access is outstanding. MEM has priority; an age counter prevents fetch starvation, and a watchdog terminates hung accesses.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, IF wait cycles after which IF beats a pending MEM request
- TIMEOUT_CYC, 64, ACCESS cycles without sram_ack before abort

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetch data, valid with if_done
- if_done  out  1  one-cycle completion pulse to IF
- mem_rd_req / mem_wr_req  in  1 each  MEM-stage load/store request, held until mem_done
- mem_addr, mem_wdata  in  ADDR_W, DATA_W  stable while requesting
- mem_rdata  out  DATA_W  load data, valid with mem_done
- mem_done  out  1  one-cycle completion pulse to MEM
- stall_if, stall_mem  out  1 each  freeze IF / MEM pipeline registers
- sram_req, sram_we  out  1 each  memory request, write enable
- sram_addr, sram_wdata  out  ADDR_W, DATA_W  memory address / write data
- sram_rdata  in  DATA_W  memory read data, valid with sram_ack
- sram_ack  in  1  memory completion, sampled only while sram_req high
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM: IDLE, ACCESS, RESP.
- IDLE: if any request pending, latch owner (IF or MEM), address, wdata, we; -> ACCESS. No request: stay.
- Grant: MEM wins unless if_req pending and if_wait >= STARVE_LIMIT, then IF wins.
- if_wait: increments (saturating at STARVE_LIMIT) each cycle if_req high and IF not owner; clears when IF granted or if_req low.
- mem_rd_req and mem_wr_req both high: treated as write.
- ACCESS: sram_req=1 with latched addr/we/wdata. On sram_ack: capture sram_rdata into owner's rdata register; -> RESP.
- Watchdog: counter clears on ACCESS entry; reaching TIMEOUT_CYC without ack -> drop sram_req, rdata=0, set timeout_err, -> RESP.
- RESP: owner's done=1 for exactly this cycle; requests ignored; -> IDLE.
- stall_if = if_req & ~if_done; stall_mem = (mem_rd_req|mem_wr_req) & ~mem_done (combinational).
- rdata registers hold last value until next capture.

## Timing
- Reset (rst low, async): state IDLE, all outputs 0, counters 0, timeout_err 0; sram_req drops immediately, even mid-ACCESS; the interrupted access is abandoned and no done pulses.
- All outputs except stall_* are registered.
- Request seen at edge N -> sram_req high cycle N+1; ack at cycle N+k -> done high cycle N+k+1. Minimum access = 3 cycles (IDLE, ACCESS, RESP); zero-wait memory acks in first ACCESS cycle.
- Requester deasserts or changes request on the edge after done; a still-held request after RESP is a new access.
- Both requests pending after RESP: re-arbitrated in IDLE with updated if_wait.
- sram_ack outside ACCESS: ignored.
- timeout_err clears only on reset.

## Structure
- Package mips_mem_pkg: FSM state enum (IDLE/ACCESS/RESP), owner enum (OWN_IF/OWN_MEM), default width constants.
- Single module; no sub-module warranted.

## Test plan
- Reset: rst low mid-ACCESS -> sram_req 0 same cycle, done pulses absent, all outputs 0.
- IF read, ack after 2 cycles, sram_rdata=0xDEADBEEF -> if_done one cycle, if_rdata=0xDEADBEEF, stall_if high until done cycle.
- MEM store addr 0x100 wdata 0x12345678 -> sram_we=1, sram_addr=0x100 held until ack, mem_done pulse.
- Simultaneous if_req and mem_rd_req, zero-wait memory -> MEM served first, IF next; continuous MEM loads -> IF granted once if_wait reaches 4.
- No ack for 64 cycles -> sram_req drops, done with rdata=0, timeout_err=1 until reset.
- mem_rd_req and mem_wr_req both high -> write issued.
